// File: rtl/freq_meas_pkg.sv
// freq_meas_pkg: shared types and defaults for the frequency-meter gate sequencer
package freq_meas_pkg;

    localparam int CNT_W_DEF = 32;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        GATE,
        SETTLE,
        LATCH
    } gate_state_t;

endpackage

// File: rtl/gate_ctrl_if.sv
// gate_ctrl_if: control/status bundle between a measurement master and the gate sequencer
interface gate_ctrl_if
    import freq_meas_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) ();

    logic             start;
    logic             cont;
    logic             abort;
    logic [CNT_W-1:0] gate_len;
    logic             cnt_en;
    logic             cnt_clr;
    logic             latch;
    logic             meas_valid;
    logic             busy;

    modport master (
        output start, cont, abort, gate_len,
        input  cnt_en, cnt_clr, latch, meas_valid, busy
    );

    modport slave (
        input  start, cont, abort, gate_len,
        output cnt_en, cnt_clr, latch, meas_valid, busy
    );

endinterface

// File: rtl/gate_timer.sv
// gate_timer: loadable down-counter that saturates at zero and flags expiry
module gate_timer
    import freq_meas_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             expire_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // reload on request, otherwise count down and hold at zero
    always_comb begin
        cnt_d = load_i ? load_val_i : (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
    end

    // counter register
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/gate_ctrl.sv
// gate_ctrl: clear/gate/settle/latch sequencer driving the edge counter and result latch
module gate_ctrl
    import freq_meas_pkg::*;
#(
    parameter int CNT_W         = CNT_W_DEF,
    parameter int CLR_CYCLES    = 1,
    parameter int SETTLE_CYCLES = 2
) (
    input logic        clk,
    input logic        reset,
    gate_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] CLR_LD = CNT_W'(CLR_CYCLES - 1);
    localparam logic [CNT_W-1:0] SET_LD = CNT_W'(SETTLE_CYCLES > 0 ? SETTLE_CYCLES - 1 : 0);

    gate_state_t      state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             tmr_load, tmr_expire;
    logic [CNT_W-1:0] tmr_val;
    logic             cnt_en_q, cnt_clr_q, latch_q, meas_valid_q, busy_q;

    gate_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expire_o   (tmr_expire)
    );

    // phase sequencing; abort overrides every other transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start || bus.cont) state_d = CLEAR;
            CLEAR:   if (tmr_expire) state_d = GATE;
            GATE:    if (tmr_expire) state_d = (SETTLE_CYCLES == 0) ? LATCH : SETTLE;
            SETTLE:  if (tmr_expire) state_d = LATCH;
            LATCH:   state_d = bus.cont ? CLEAR : IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.abort) state_d = IDLE;
    end

    // gate length is snapshotted as a new measurement begins; zero means one cycle
    always_comb begin
        len_d = (state_d == CLEAR && state_q != CLEAR)
              ? ((bus.gate_len == '0) ? CNT_W'(1) : bus.gate_len)
              : len_q;
    end

    // timer reloads with the remaining-cycle count of whichever phase is entered
    always_comb begin
        tmr_load = (state_d != state_q);
        tmr_val  = (state_d == CLEAR)  ? CLR_LD :
                   (state_d == GATE)   ? len_q - CNT_W'(1) :
                   (state_d == SETTLE) ? SET_LD : '0;
    end

    // state, shadow length and outputs registered from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            len_q        <= '0;
            cnt_en_q     <= 1'b0;
            cnt_clr_q    <= 1'b0;
            latch_q      <= 1'b0;
            meas_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            cnt_en_q     <= (state_d == GATE);
            cnt_clr_q    <= (state_d == CLEAR);
            latch_q      <= (state_d == LATCH);
            meas_valid_q <= (state_q == LATCH) && !bus.abort;
            busy_q       <= (state_d != IDLE);
        end
    end

    assign bus.cnt_en     = cnt_en_q;
    assign bus.cnt_clr    = cnt_clr_q;
    assign bus.latch      = latch_q;
    assign bus.meas_valid = meas_valid_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_gate_ctrl.sv
// tb_gate_ctrl: table, directed and randomized checks of gate_ctrl against a timeline model
module tb_gate_ctrl;

    localparam int C = 1;

    typedef struct {
        bit          st;
        bit          co;
        bit          ab;
        logic [31:0] gl;
        logic [4:0]  ex;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   n = 0;
    bit   armed = 1'b0;
    bit   act[2];
    int   s[2];
    longint len[2];
    bit   mvn[2];
    int   sv[2] = '{2, 0};
    logic [4:0] o[2];
    vec_t tbl[12];
    bit   contlvl = 1'b0;

    always #5 clk = ~clk;

    gate_ctrl_if #(.CNT_W(32)) bus0 ();
    gate_ctrl_if #(.CNT_W(32)) bus1 ();

    gate_ctrl #(.CNT_W(32), .CLR_CYCLES(1), .SETTLE_CYCLES(2)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    gate_ctrl #(.CNT_W(32), .CLR_CYCLES(1), .SETTLE_CYCLES(0)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    function automatic longint cap(input logic [31:0] g);
        return (g == 0) ? 64'd1 : longint'(g);
    endfunction

    // expected {busy, cnt_clr, cnt_en, latch, meas_valid} from the offset into the current measurement
    function automatic logic [4:0] model_exp(input int d);
        longint k = longint'(n - s[d]);
        longint t = C + len[d] + sv[d] + 1;
        return {act[d], act[d] && k <= C, act[d] && k > C && k <= C + len[d], act[d] && k == t, mvn[d]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, n, a, e);
        end
    endtask

    task automatic cyc(input bit st, input bit co, input bit ab, input bit rs, input logic [31:0] gl);
        @(negedge clk);
        o[0] = {bus0.busy, bus0.cnt_clr, bus0.cnt_en, bus0.latch, bus0.meas_valid};
        o[1] = {bus1.busy, bus1.cnt_clr, bus1.cnt_en, bus1.latch, bus1.meas_valid};
        if (armed)
            for (int d = 0; d < 2; d++) chk(d == 0 ? "model_settle2" : "model_settle0", o[d], model_exp(d));
        bus0.start = st; bus0.cont = co; bus0.abort = ab; bus0.gate_len = gl;
        bus1.start = st; bus1.cont = co; bus1.abort = ab; bus1.gate_len = gl;
        reset = rs;
        for (int d = 0; d < 2; d++) begin
            bit mv;
            mv = 1'b0;
            if (rs) begin
                act[d] = 1'b0;
            end else if (act[d]) begin
                if (ab) act[d] = 1'b0;
                else if (longint'(n - s[d]) == C + len[d] + sv[d] + 1) begin
                    mv = 1'b1;
                    if (co) begin s[d] = n; len[d] = cap(gl); end
                    else act[d] = 1'b0;
                end
            end else if ((st || co) && !ab) begin
                act[d] = 1'b1;
                s[d]   = n;
                len[d] = cap(gl);
            end
            mvn[d] = mv;
        end
        armed = 1'b1;
        n++;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(0, 0, 0, 0, 5);
    endtask

    task automatic run_table();
        for (int i = 0; i < 12; i++) begin
            cyc(tbl[i].st, tbl[i].co, tbl[i].ab, 0, tbl[i].gl);
            chk("table", o[0], tbl[i].ex);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        tbl = '{
            '{1, 0, 0, 32'd5, 5'b00000},
            '{0, 0, 0, 32'd5, 5'b11000},
            '{0, 0, 0, 32'd5, 5'b10100},
            '{0, 0, 0, 32'd5, 5'b10100},
            '{1, 0, 0, 32'd5, 5'b10100},
            '{0, 0, 0, 32'd9, 5'b10100},
            '{0, 0, 0, 32'd9, 5'b10100},
            '{0, 0, 0, 32'd5, 5'b10000},
            '{0, 0, 0, 32'd5, 5'b10000},
            '{0, 0, 0, 32'd5, 5'b10010},
            '{0, 0, 0, 32'd5, 5'b00001},
            '{0, 0, 0, 32'd5, 5'b00000}
        };
        bus0.start = 0; bus0.cont = 0; bus0.abort = 0; bus0.gate_len = 0;
        bus1.start = 0; bus1.cont = 0; bus1.abort = 0; bus1.gate_len = 0;
        cyc(0, 0, 0, 1, 5);
        cyc(0, 0, 0, 1, 5);
        cyc(0, 0, 0, 0, 5);
        chk("reset_state", o[0], 5'b00000);
        idle(2);
        run_table();
        idle(2);
        for (int i = 0; i <= 28; i++) begin
            cyc(0, i < 27, 0, 0, 5);
            chk("cont_latch", o[0][1], i > 0 && i % 9 == 0);
            chk("cont_clr", o[0][3], i % 9 == 1 && i <= 27);
            chk("cont_busy", o[0][4], i >= 1 && i <= 27);
        end
        idle(2);
        for (int i = 0; i < 8; i++) begin
            cyc(i == 0, 0, 0, 0, 0);
            chk("len0_en", o[0][2], i == 2);
            chk("len0_latch", o[0][1], i == 5);
        end
        idle(2);
        for (int i = 0; i < 16; i++) begin
            cyc(i == 0, 0, i == 4, 0, 5);
            chk("abort_en", o[0][2], i >= 2 && i <= 4);
            chk("abort_busy", o[0][4], i >= 1 && i <= 4);
            chk("abort_strobes", o[0][1:0], 2'b00);
        end
        run_table();
        idle(2);
        for (int i = 0; i < 7; i++) begin
            cyc(i == 0, 0, 0, i == 3, 5);
            if (i == 3) chk("pre_reset_en", o[0][2], 1);
            if (i >= 4) chk("reset_mid_gate", o[0], 5'b00000);
        end
        idle(2);
        for (int i = 0; i <= 36; i++) begin
            cyc(0, i < 12, 0, 0, i < 3 ? 32'd5 : 32'd20);
            chk("relen_en", o[0][2], (i >= 2 && i <= 6) || (i >= 11 && i <= 30));
            chk("relen_busy", o[0][4], i >= 1 && i <= 33);
            chk("relen_latch", o[0][1], i == 9 || i == 33);
        end
        idle(2);
        cyc(1, 0, 1, 0, 5);
        cyc(0, 0, 0, 0, 5);
        chk("start_abort_idle", o[0], 5'b00000);
        cyc(0, 0, 0, 0, 5);
        chk("start_abort_idle2", o[0], 5'b00000);
        for (int i = 0; i < 8; i++) begin
            cyc(i == 0, 0, i == 5, 0, 1);
            if (i == 5) chk("abort_latch_strobe", o[0][1], 1);
            if (i == 6) chk("abort_latch_after", o[0], 5'b00000);
        end
        idle(2);
        for (int i = 0; i < 8; i++) begin
            cyc(i == 0, 0, 0, 0, 3);
            chk("s0_en", o[1][2], i >= 2 && i <= 4);
            chk("s0_latch", o[1][1], i == 5);
            chk("s0_valid", o[1][0], i == 6);
        end
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 49) == 0) contlvl = ~contlvl;
            cyc($urandom_range(0, 9) == 0, contlvl, $urandom_range(0, 39) == 0,
                $urandom_range(0, 59) == 0, 32'($urandom_range(0, 6)));
        end
        idle(20);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
